// File: rtl/mod_cfg_pkg.sv
// mod_cfg_pkg: shared state encoding, switch-word layout and defaults for the MOD setting controller
package mod_cfg_pkg;
    localparam int FREQ_W = 3;
    localparam int PHASE_W = 5;
    localparam int DUTY_W = 4;
    localparam int WORD_W = FREQ_W + PHASE_W + DUTY_W;
    localparam int DEF_MAX_FREQ_SEL = 2;
    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_DEBOUNCE,
        ST_BLANK_PRE,
        ST_APPLY,
        ST_BLANK_POST
    } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, cleared by reset
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;

    // first flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/mod_setting_ctrl.sv
// mod_setting_ctrl: debounces switch settings and applies them with output blanking, gated by PLL lock
module mod_setting_ctrl
    import mod_cfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int GATE_CYCLES     = 64,
    parameter int MAX_FREQ_SEL    = DEF_MAX_FREQ_SEL
) (
    input  logic               USER_CLOCK,
    input  logic               RESET_N,
    input  logic               PLL_LOCKED,
    input  logic [FREQ_W-1:0]  SW_FREQ_SEL,
    input  logic [PHASE_W-1:0] SW_PHASE_SEL,
    input  logic [DUTY_W-1:0]  SW_DUTY_SEL,
    output logic [FREQ_W-1:0]  FREQ_SEL,
    output logic [PHASE_W-1:0] PHASE_SEL,
    output logic [DUTY_W-1:0]  DUTY_SEL,
    output logic               OUT_EN,
    output logic               UPDATE_PULSE,
    output logic               CFG_ERR
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [WORD_W:0]   w_sync;
    logic              w_lock;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_applied;
    logic [WORD_W-1:0] r_cand;
    logic [WORD_W-1:0] r_rej;
    logic [DW-1:0]     r_deb_cnt;
    logic [DW-1:0]     w_deb_next;
    logic              w_deb_done;
    logic [GW-1:0]     r_gate_cnt;
    logic              w_gate_done;
    logic              w_cand_ok;
    state_t            r_state;

    // reset asserts at once but releases only after two clean clock edges
    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    sync_2ff #(.WIDTH(WORD_W + 1)) u_sync (
        .i_clk   (USER_CLOCK),
        .i_rst_n (w_rst_n),
        .i_d     ({PLL_LOCKED, SW_FREQ_SEL, SW_PHASE_SEL, SW_DUTY_SEL}),
        .o_q     (w_sync)
    );

    assign w_lock      = w_sync[WORD_W];
    assign w_word      = w_sync[WORD_W-1:0];
    assign w_applied   = {FREQ_SEL, PHASE_SEL, DUTY_SEL};
    assign w_deb_next  = r_deb_cnt + DW'(1);
    // the capture cycle counts as the first stable sample, so acceptance comes when the count reaches the last index
    assign w_deb_done  = (r_deb_cnt == DEB_LAST) || (w_deb_next == DEB_LAST);
    assign w_gate_done = r_gate_cnt == GATE_LAST;
    assign w_cand_ok   = int'(r_cand[WORD_W-1 -: FREQ_W]) <= MAX_FREQ_SEL;

    // control FSM: lock qualification, debounce, validation and blanked apply; lock loss overrides every state
    always_ff @(posedge USER_CLOCK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_WAIT_LOCK;
            r_cand       <= '0;
            r_rej        <= '0;
            r_deb_cnt    <= '0;
            r_gate_cnt   <= '0;
            FREQ_SEL     <= '0;
            PHASE_SEL    <= '0;
            DUTY_SEL     <= '0;
            OUT_EN       <= 1'b0;
            UPDATE_PULSE <= 1'b0;
            CFG_ERR      <= 1'b0;
        end else begin
            UPDATE_PULSE <= 1'b0;
            if (!w_lock) begin
                r_state    <= ST_WAIT_LOCK;
                OUT_EN     <= 1'b0;
                r_gate_cnt <= '0;
                r_deb_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_WAIT_LOCK: begin
                        if (w_gate_done) begin
                            r_state <= ST_IDLE;
                            OUT_EN  <= 1'b1;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + GW'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (w_word != w_applied && !(CFG_ERR && w_word == r_rej)) begin
                            r_state   <= ST_DEBOUNCE;
                            r_cand    <= w_word;
                            r_deb_cnt <= '0;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (w_word == w_applied) begin
                            r_state <= ST_IDLE;
                        end else if (w_word != r_cand) begin
                            r_cand    <= w_word;
                            r_deb_cnt <= '0;
                        end else if (w_deb_done) begin
                            if (w_cand_ok) begin
                                CFG_ERR    <= 1'b0;
                                r_rej      <= '0;
                                r_state    <= ST_BLANK_PRE;
                                OUT_EN     <= 1'b0;
                                r_gate_cnt <= '0;
                            end else begin
                                CFG_ERR <= 1'b1;
                                r_rej   <= r_cand;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_deb_cnt <= w_deb_next;
                        end
                    end
                    ST_BLANK_PRE: begin
                        if (w_gate_done) begin
                            r_state                          <= ST_APPLY;
                            {FREQ_SEL, PHASE_SEL, DUTY_SEL}  <= r_cand;
                            UPDATE_PULSE                     <= 1'b1;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + GW'(1);
                        end
                    end
                    ST_APPLY: begin
                        r_state    <= ST_BLANK_POST;
                        r_gate_cnt <= '0;
                    end
                    ST_BLANK_POST: begin
                        if (w_gate_done) begin
                            r_state <= ST_IDLE;
                            OUT_EN  <= 1'b1;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + GW'(1);
                        end
                    end
                    default: r_state <= ST_WAIT_LOCK;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mod_setting_ctrl.sv
// tb_mod_setting_ctrl: directed and randomized checks of the setting controller against a settled-word reference model
module tb_mod_setting_ctrl;
    localparam int DEB = 8;
    localparam int GATE = 4;
    localparam int MAXF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic lock = 1'b0;
    logic [2:0] sw_f = '0;
    logic [4:0] sw_p = '0;
    logic [3:0] sw_d = '0;
    logic [2:0] freq;
    logic [4:0] phase;
    logic [3:0] duty;
    logic out_en, upd, err;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    logic [11:0] exp_q[$];
    logic [11:0] m_app = '0;
    logic [11:0] m_rej = '0;
    logic m_err = 1'b0;
    logic prev_oe = 1'b0;
    logic [2:0] prev_f = '0;

    mod_setting_ctrl #(.DEBOUNCE_CYCLES(DEB), .GATE_CYCLES(GATE), .MAX_FREQ_SEL(MAXF)) dut (
        .USER_CLOCK   (clk),
        .RESET_N      (rst_n),
        .PLL_LOCKED   (lock),
        .SW_FREQ_SEL  (sw_f),
        .SW_PHASE_SEL (sw_p),
        .SW_DUTY_SEL  (sw_d),
        .FREQ_SEL     (freq),
        .PHASE_SEL    (phase),
        .DUTY_SEL     (duty),
        .OUT_EN       (out_en),
        .UPDATE_PULSE (upd),
        .CFG_ERR      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input logic [11:0] w);
        {sw_f, sw_p, sw_d} = w;
    endtask

    // outcome of a switch word that has settled long enough: applied once, rejected, or ignored
    task automatic model_settle(input logic [11:0] w);
        if (w != m_app && !(m_err && w == m_rej)) begin
            if (int'(w[11:9]) > MAXF) begin
                m_err = 1'b1;
                m_rej = w;
            end else begin
                exp_q.push_back(w);
                m_app = w;
                m_err = 1'b0;
            end
        end
    endtask

    task automatic wait_oe(input logic lvl, input int limit, output int n);
        n = 0;
        while (out_en !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while (upd !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_final(input string tag);
        check({tag, "_word"}, 32'({freq, phase, duty}), 32'(m_app));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_oe"}, 32'(out_en), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // monitor: every pulse must match the next expected word; FREQ_SEL must hold while outputs are enabled
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            pulses++;
            check("pulse_oe", 32'(out_en), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got word 0x%0h, expected no pulse", {freq, phase, duty});
            end else begin
                check("pulse_word", 32'({freq, phase, duty}), 32'(exp_q.pop_front()));
            end
        end
        if (out_en === 1'b1 && prev_oe === 1'b1) check("freq_stable", 32'(freq), 32'(prev_f));
        prev_oe = out_en;
        prev_f = freq;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, lows;
        logic [11:0] w;
        lock = 1'b1;
        set_word(12'hABC);
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_freq", 32'(freq), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_oe", 32'(out_en), 32'd0);
        check("rst_upd", 32'(upd), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        set_word(12'h000);
        tick(1);
        rst_n = 1'b1;
        wait_oe(1'b1, 30, n);
        check("lock_latency", 32'(n), 32'd8);

        w = {3'd1, 5'd0, 4'd0};
        set_word(w);
        model_settle(w);
        wait_oe(1'b0, 40, n);
        check("deb_latency", 32'(n), 32'd10);
        wait_pulse(20, n);
        check("pre_blank_len", 32'(n), 32'd4);
        check("apply_freq", 32'(freq), 32'd1);
        wait_oe(1'b1, 20, n);
        check("post_blank_len", 32'(n), 32'd5);
        check_final("freq1");

        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            set_word({3'd1, (i % 2 == 0) ? 5'd3 : 5'd7, 4'd0});
            tick(3);
        end
        w = {3'd1, 5'd7, 4'd0};
        set_word(w);
        model_settle(w);
        tick(40);
        check("toggle_pulses", 32'(pulses - p0), 32'd1);
        check("toggle_phase", 32'(phase), 32'd7);
        check_final("toggle");

        w = {3'd3, 5'd7, 4'd0};
        set_word(w);
        model_settle(w);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (out_en !== 1'b1) lows++;
        end
        check("rej_oe_lows", 32'(lows), 32'd0);
        check("rej_err", 32'(err), 32'd1);
        check("rej_freq", 32'(freq), 32'd1);
        w = {3'd2, 5'd7, 4'd0};
        set_word(w);
        model_settle(w);
        tick(40);
        check("legal_freq", 32'(freq), 32'd2);
        check_final("legal");

        w = {3'd0, 5'd7, 4'd5};
        set_word(w);
        model_settle(w);
        p0 = pulses;
        wait_oe(1'b0, 40, n);
        check("drop_deb_latency", 32'(n), 32'd10);
        tick(1);
        lock = 1'b0;
        tick(3);
        check("drop_no_pulse", 32'(pulses - p0), 32'd0);
        check("drop_retain", 32'({freq, phase, duty}), 32'({3'd2, 5'd7, 4'd0}));
        check("drop_oe", 32'(out_en), 32'd0);
        lock = 1'b1;
        tick(50);
        check("relock_pulses", 32'(pulses - p0), 32'd1);
        check_final("relock");

        set_word({3'd1, 5'd2, 4'd3});
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_freq", 32'(freq), 32'd0);
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_duty", 32'(duty), 32'd0);
        check("midrst_oe", 32'(out_en), 32'd0);
        check("midrst_upd", 32'(upd), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        m_app = '0;
        m_rej = '0;
        m_err = 1'b0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        model_settle({3'd1, 5'd2, 4'd3});
        tick(50);
        check_final("after_rst");

        for (int s = 0; s < 40; s++) begin
            int r, ng;
            r = $urandom_range(0, 9);
            w = {3'($urandom_range(0, 4)), 5'($urandom), 4'($urandom)};
            if (r == 0) w = m_app;
            else if (r == 1 && m_err) w = m_rej;
            ng = $urandom_range(0, 5);
            for (int g = 0; g < ng; g++) begin
                set_word(12'($urandom));
                tick($urandom_range(1, 3));
            end
            set_word(w);
            model_settle(w);
            if ($urandom_range(0, 2) == 0) begin
                tick($urandom_range(0, 25));
                lock = 1'b0;
                tick($urandom_range(1, 4));
                lock = 1'b1;
            end
            tick(45);
            check_final("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
